// File: rtl/mips_mem_pkg.sv
// Purpose : shared types and constants for the data-memory arbiter slice.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package mips_mem_pkg;

    // Sequencer states for one memory access.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    // Which requester owns the memory port.
    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int DEFAULT_AW = 8;
    localparam int MAX_RD_LAT = 4;
    localparam int WAIT_CNT_W = $clog2(MAX_RD_LAT);

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Purpose : two-input alternating-priority arbiter; remembers the last owner.
// Latency : grant is combinational from req; last_owner updates on the edge where update=1.
// Backpr. : none; the loser simply keeps requesting until it is granted.
//
// Ports: clock/reset (sync, active-low), req[0]=cpu, req[1]=host,
//        update (a grant is being taken this cycle), grant (winning owner).
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output owner_t     grant
);

    owner_t last_owner;

    // A lone requester always wins; on contention the one that did not
    // go last wins, so two persistent requesters strictly alternate.
    always_comb begin
        grant = last_owner;
        case (req)
            2'b01:   grant = OWN_CPU;
            2'b10:   grant = OWN_HOST;
            2'b11:   grant = other_owner(last_owner);
            default: grant = last_owner;
        endcase
    end

    // Coming out of reset the host counts as last owner, so the CPU wins a tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_owner <= OWN_HOST;
        end else if (update) begin
            last_owner <= grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : serialises CPU load/store and host preload/readback onto one synchronous data memory.
// Latency : write ack 2 cycles after the request is first seen in IDLE, read ack 2+RD_LAT cycles.
// Backpr. : CPU is frozen through cpu_stall until its ACK cycle; host holds host_valid until host_ready.
//
// Ports: clock/reset (sync, active-low); cpu_read/cpu_write/cpu_addr/cpu_wdata in,
//        cpu_rdata/cpu_stall out; host_valid/host_write/host_addr/host_wdata in,
//        host_ready/host_rdata out; mem_read/mem_write/mem_addr/mem_din out, mem_dout in.
//        RD_LAT must lie in 1..MAX_RD_LAT.
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW     = DEFAULT_AW,
    parameter int RD_LAT = 1
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_valid,
    input  logic          host_write,
    input  logic [31:0]   host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_ready,
    output logic [31:0]   host_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(RD_LAT - 1);

    state_t                state;
    owner_t                owner;
    owner_t                grant;
    logic                  op_write;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  cpu_ack;
    logic                  cpu_req;
    logic                  grant_vld;

    // Byte-offset bits and bits above the memory size play no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                                host_addr[31:AW+2], host_addr[1:0]};

    assign cpu_req   = cpu_read | cpu_write;
    assign grant_vld = (state == IDLE) && (cpu_req || host_valid);

    // Low in the ACK cycle so the core retires the instruction on that edge.
    assign cpu_stall = cpu_req & ~cpu_ack;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({host_valid, cpu_req}),
        .update (grant_vld),
        .grant  (grant)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_HOST;
            op_write   <= 1'b0;
            wait_cnt   <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            host_ready <= 1'b0;
            host_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-set below.
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            host_ready <= 1'b0;
            cpu_ack    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner <= grant;
                        state <= ISSUE;
                        if (grant == OWN_CPU) begin
                            // Read and write together resolve to a write.
                            op_write  <= cpu_write;
                            mem_write <= cpu_write;
                            mem_read  <= ~cpu_write;
                            mem_addr  <= cpu_addr[AW+1:2];
                            mem_din   <= cpu_wdata;
                        end else begin
                            op_write  <= host_write;
                            mem_write <= host_write;
                            mem_read  <= ~host_write;
                            mem_addr  <= host_addr[AW+1:2];
                            mem_din   <= host_wdata;
                        end
                    end
                end

                ISSUE: begin
                    if (op_write) begin
                        state      <= ACK;
                        host_ready <= (owner == OWN_HOST);
                        cpu_ack    <= (owner == OWN_CPU);
                    end else begin
                        state    <= RD_WAIT;
                        wait_cnt <= '0;
                    end
                end

                RD_WAIT: begin
                    // mem_dout is valid in the last wait cycle only.
                    if (wait_cnt == LAST_WAIT) begin
                        state <= ACK;
                        if (owner == OWN_HOST) begin
                            host_rdata <= mem_dout;
                            host_ready <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_dout;
                            cpu_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ACK: begin
                    // Always via IDLE: a request still held here is not re-granted.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
